controle_venda: RTL and testbench

Vending-machine control FSM that sits directly upstream of the end-of-operation shift register. It accumulates coin credit, accepts a product selection or cancel, and drives LP (release product) and DM (return coins). It consumes that register's FIM output as the "operation finished" acknowledge before returning to idle. It runs on the same clk as that register.

---
 rtl/vm_pkg.sv | 25 ++
 rtl/moeda_dec.sv | 39 +++
 rtl/controle_venda.sv | 128 ++++++++++++
 tb/tb_controle_venda.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine controller.
package vm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CREDITO,
    LIBERA,
    DEVOLVE,
    ESPERA
  } state_t;

  localparam logic [1:0] COD_INV = 2'b00;
  localparam logic [1:0] COD_25  = 2'b01;
  localparam logic [1:0] COD_50  = 2'b10;
  localparam logic [1:0] COD_100 = 2'b11;

  localparam int VAL_25  = 25;
  localparam int VAL_50  = 50;
  localparam int VAL_100 = 100;

  localparam int PRECO_DEF    = 150;
  localparam int MAX_CRED_DEF = 250;
  localparam int CRED_W_DEF   = 8;

endpackage

// File: rtl/moeda_dec.sv
// Combinational coin decoder: coin code to credit value plus a valid flag.
module moeda_dec
  import vm_pkg::*;
#(
  parameter int CRED_W = CRED_W_DEF
) (
  input  logic [1:0]        moeda_cod,
  output logic [CRED_W-1:0] valor,
  output logic              valido
);

  always_comb begin
    valor  = '0;
    valido = 1'b0;
    case (moeda_cod)
      COD_25: begin
        valor  = CRED_W'(VAL_25);
        valido = 1'b1;
      end
      COD_50: begin
        valor  = CRED_W'(VAL_50);
        valido = 1'b1;
      end
      COD_100: begin
        valor  = CRED_W'(VAL_100);
        valido = 1'b1;
      end
      COD_INV: begin
        valor  = '0;
        valido = 1'b0;
      end
      default: begin
        valor  = '0;
        valido = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/controle_venda.sv
// Vending-machine control FSM: accumulates credit, releases product (LP) or
// returns change (DM), and handshakes with the end register through FIM.
module controle_venda
  import vm_pkg::*;
#(
  parameter int PRECO    = PRECO_DEF,
  parameter int MAX_CRED = MAX_CRED_DEF,
  parameter int CRED_W   = CRED_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              moeda_ok,
  input  logic [1:0]        moeda_cod,
  input  logic              sel,
  input  logic              cancel,
  input  logic              FIM,
  output logic              LP,
  output logic              DM,
  output logic [CRED_W-1:0] credito,
  output logic [CRED_W-1:0] troco,
  output logic              moeda_rej
);

  state_t              state, state_n;
  logic [CRED_W-1:0]   credito_n, troco_n;
  logic                lp_n, dm_n, rej_n;
  logic [CRED_W-1:0]   valor;
  logic                valido;
  logic [CRED_W:0]     soma;
  logic                pode_comprar;

  moeda_dec #(.CRED_W(CRED_W)) u_moeda_dec (
    .moeda_cod (moeda_cod),
    .valor     (valor),
    .valido    (valido)
  );

  // One extra bit so an over-limit sum can never wrap back under MAX_CRED.
  assign soma         = {1'b0, credito} + {1'b0, valor};
  assign pode_comprar = (credito >= CRED_W'(PRECO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      credito   <= '0;
      troco     <= '0;
      LP        <= 1'b0;
      DM        <= 1'b0;
      moeda_rej <= 1'b0;
    end else begin
      state     <= state_n;
      credito   <= credito_n;
      troco     <= troco_n;
      LP        <= lp_n;
      DM        <= dm_n;
      moeda_rej <= rej_n;
    end
  end

  always_comb begin
    state_n   = state;
    credito_n = credito;
    troco_n   = troco;
    rej_n     = 1'b0;
    case (state)
      IDLE: begin
        credito_n = '0;
        // A high FIM here is a leftover acknowledge, so no new sale starts.
        if (moeda_ok) begin
          if (valido && !FIM) begin
            credito_n = valor;
            state_n   = CREDITO;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      CREDITO: begin
        if (cancel) begin
          troco_n = credito;
          state_n = DEVOLVE;
          rej_n   = moeda_ok;
        end else if (sel && pode_comprar) begin
          troco_n   = credito - CRED_W'(PRECO);
          credito_n = credito - CRED_W'(PRECO);
          state_n   = LIBERA;
          rej_n     = moeda_ok;
        end else if (moeda_ok) begin
          if (valido && (soma <= (CRED_W+1)'(MAX_CRED))) begin
            credito_n = soma[CRED_W-1:0];
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      LIBERA: begin
        rej_n = moeda_ok;
        if (FIM) state_n = ESPERA;
      end
      DEVOLVE: begin
        rej_n = moeda_ok;
        if (FIM) begin
          troco_n   = '0;
          credito_n = '0;
          state_n   = ESPERA;
        end
      end
      ESPERA: begin
        rej_n = moeda_ok;
        if (!FIM) begin
          if (troco != '0) begin
            state_n = DEVOLVE;
          end else begin
            credito_n = '0;
            state_n   = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Deriving LP/DM from the next state keeps them exclusive by construction.
    lp_n = (state_n == LIBERA);
    dm_n = (state_n == DEVOLVE);
  end

endmodule

// File: tb/tb_controle_venda.sv
// Directed bench for controle_venda with a 4-stage end-register model on FIM.
module tb_controle_venda;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       moeda_ok = 1'b0;
  logic [1:0] moeda_cod = 2'b00;
  logic       sel = 1'b0;
  logic       cancel = 1'b0;
  logic       FIM;
  logic       LP, DM, moeda_rej;
  logic [7:0] credito, troco;

  logic [3:0] end_sr = 4'b0000;
  int total = 0;
  int bad = 0;
  int lp_cycles = 0;
  int dm_cycles = 0;
  int both_cycles = 0;
  int lp0, dm0;

  controle_venda dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .moeda_ok  (moeda_ok),
    .moeda_cod (moeda_cod),
    .sel       (sel),
    .cancel    (cancel),
    .FIM       (FIM),
    .LP        (LP),
    .DM        (DM),
    .credito   (credito),
    .troco     (troco),
    .moeda_rej (moeda_rej)
  );

  always #5 clk = ~clk;

  // End register model: not reset, FIM follows LP|DM four edges later.
  always @(posedge clk) end_sr <= {end_sr[2:0], LP | DM};
  assign FIM = end_sr[3];

  always @(negedge clk) begin
    if (LP) lp_cycles++;
    if (DM) dm_cycles++;
    if (LP && DM) both_cycles++;
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ok, input logic [1:0] cod,
                               input logic s, input logic c);
    moeda_ok  = ok;
    moeda_cod = cod;
    sel       = s;
    cancel    = c;
    step();
    moeda_ok  = 1'b0;
    moeda_cod = 2'b00;
    sel       = 1'b0;
    cancel    = 1'b0;
  endtask

  task automatic waitFim(input logic lvl, input string tag);
    int n = 0;
    while (FIM !== lvl && n < 20) begin
      step();
      n++;
    end
    checkOutput(tag, int'(FIM), int'(lvl));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    moeda_ok = 1'b0; moeda_cod = 2'b00; sel = 1'b0; cancel = 1'b0;
    waitFim(1'b0, "rst_fim_drain");
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Full sale with exact price
    doReset();
    checkOutput("rst_lp", LP, 0);
    checkOutput("rst_dm", DM, 0);
    checkOutput("rst_credito", credito, 0);
    checkOutput("rst_troco", troco, 0);
    checkOutput("rst_rej", moeda_rej, 0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("t1_cred100", credito, 100);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("t1_cred150", credito, 150);
    dm0 = dm_cycles;
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("t1_lp_on", LP, 1);
    checkOutput("t1_cred0", credito, 0);
    checkOutput("t1_troco0", troco, 0);
    repeat (3) step();
    checkOutput("t1_fim_early", FIM, 0);
    step();
    checkOutput("t1_fim_rise", FIM, 1);
    checkOutput("t1_lp_held", LP, 1);
    step();
    checkOutput("t1_lp_off", LP, 0);
    waitFim(1'b0, "t1_fim_fall");
    step();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("t1_idle_coin", credito, 25);
    checkOutput("t1_dm_never", dm_cycles - dm0, 0);

    // Sale with change
    doReset();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("t2_cred200", credito, 200);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("t2_lp_on", LP, 1);
    checkOutput("t2_troco50", troco, 50);
    waitFim(1'b1, "t2_fim_rise1");
    step();
    checkOutput("t2_lp_off", LP, 0);
    checkOutput("t2_dm_off", DM, 0);
    waitFim(1'b0, "t2_fim_fall1");
    step();
    checkOutput("t2_dm_on", DM, 1);
    checkOutput("t2_dm_troco", troco, 50);
    waitFim(1'b1, "t2_fim_rise2");
    step();
    checkOutput("t2_dm_drop", DM, 0);
    checkOutput("t2_troco_clr", troco, 0);
    checkOutput("t2_cred_clr", credito, 0);
    waitFim(1'b0, "t2_fim_fall2");
    step();
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("t2_idle_coin", credito, 50);

    // Cancel returns all credit
    doReset();
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    lp0 = lp_cycles;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("t3_dm_on", DM, 1);
    checkOutput("t3_troco50", troco, 50);
    checkOutput("t3_lp_off", LP, 0);
    waitFim(1'b1, "t3_fim_rise");
    step();
    checkOutput("t3_dm_drop", DM, 0);
    checkOutput("t3_troco_clr", troco, 0);
    waitFim(1'b0, "t3_fim_fall");
    step();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("t3_idle_coin", credito, 25);
    checkOutput("t3_lp_never", lp_cycles - lp0, 0);

    // Credit limit and coin alongside an accepted select
    doReset();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("t4_rej_on", moeda_rej, 1);
    checkOutput("t4_cred_kept", credito, 200);
    step();
    checkOutput("t4_rej_pulse", moeda_rej, 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("t4_cred250", credito, 250);
    checkOutput("t4_rej_off", moeda_rej, 0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("t4_inv_rej", moeda_rej, 1);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
    checkOutput("t4_sel_lp", LP, 1);
    checkOutput("t4_sel_rej", moeda_rej, 1);
    checkOutput("t4_sel_troco", troco, 100);

    // Cancel beats select; select below price ignored
    doReset();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    checkOutput("t5_dm_on", DM, 1);
    checkOutput("t5_troco150", troco, 150);
    checkOutput("t5_lp_off", LP, 0);
    doReset();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("t5_lowsel_lp", LP, 0);
    checkOutput("t5_lowsel_cred", credito, 100);
    checkOutput("t5_lowsel_troco", troco, 0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("t5_still_cred", credito, 150);

    // Reset in the middle of a release, with stale FIM
    doReset();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    repeat (4) step();
    checkOutput("t6_lp_before", LP, 1);
    checkOutput("t6_fim_high", FIM, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_lp_async", LP, 0);
    checkOutput("t6_cred_async", credito, 0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("t6_stale_rej", moeda_rej, 1);
    checkOutput("t6_stale_cred", credito, 0);
    waitFim(1'b0, "t6_fim_fall");
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("t6_accept_cred", credito, 100);
    checkOutput("t6_accept_rej", moeda_rej, 0);

    checkOutput("lp_dm_exclusive", both_cycles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
